current_source_array: RTL and testbench
=======================================

Name: current_source_array

Overview:
- Parametrised clocked successor of the fixed 17-thermometer/6-binary current-source unit RNM model. Used by the current-steering DAC macro.
- Adds a debounced supply/reference monitor and a soft-start sequencer that turns thermometer units on one at a time.
- Adds a latched fault state and a selectable thermometer tap on the analog test bus.
- Outputs are Cadence RNM reals. Undriven outputs are high-impedance (`wrealZState`).

Parameters:
- N_THERM, 17, number of thermometer unit outputs (2..64).
- N_BIN, 6, number of binary-weighted outputs.
- RATIO, 0.4, unit current IUNIT = iref_500ua*RATIO.
- RAMP_STEP, 4, clock cycles between successive unit enables (>=1).
- DEB_CYCLES, 8, consecutive cycles a check must hold before state changes (>=1).
- IREF_TOL, 0.10, relative tolerance on iref_500ua around 500e-6.
- VDD_TOL, 0.05, relative tolerance on 1.8 V and 0.8 V supplies; vssana window is ±0.05 V absolute.

Ports:
- clk  input  1  sequencer clock.
- rstb  input  1  asynchronous active-low reset.
- pdb  input  1  power-down negate; 1 = enable.
- atb_ena  input  2  analog test bus mode.
- atb_sel  input  $clog2(N_THERM)  thermometer index routed to atb0 in mode 10.
- iref_500ua  input  real  reference current.
- vddana_1p8, vddana_0p8, vssana  input  real  supplies.
- Iout_therm  output  real[N_THERM]  thermometer unit currents.
- Iout_binary  output  real[N_BIN]  binary currents; index N_BIN-1 is the MSB.
- Iout_binary_red  output  real  redundant LSB current.
- atb1, atb0  output  real  analog test bus.
- ready  output  1  all units on.
- fault  output  1  latched supply/reference fault.

Behaviour:
- Checks are combinational from the inputs and sampled on each rising clk edge. good = all four checks pass.
- Reset (rstb=0, asynchronous): state OFF, counters 0, ready=0, fault=0, every real output Z.
- States: OFF, CHECK, RAMP, ON, FAULT.
- OFF:
  - All currents Z, ready=0.
  - pdb=1 → CHECK with deb_cnt cleared.
- CHECK:
  - good increments deb_cnt; !good clears it.
  - deb_cnt reaching DEB_CYCLES → RAMP with n_on=0, step_cnt=0.
- RAMP:
  - step_cnt counts 0..RAMP_STEP-1. On wrap, n_on increments.
  - Iout_therm[i] = IUNIT when i<n_on, else Z.
  - On the wrap after n_on=N_THERM, binary and red outputs are enabled and state → ON.
- ON:
  - ready=1.
  - All Iout_therm = IUNIT.
  - Iout_binary[k] = IUNIT/2^(N_BIN-k).
  - Iout_binary_red = IUNIT/2^N_BIN.
- Fault debounce in RAMP/ON:
  - Separate bad_cnt: increments on !good, clears on good.
  - bad_cnt reaching DEB_CYCLES → FAULT.
  - Single-cycle glitches shorter than DEB_CYCLES are ignored.
- FAULT:
  - fault=1, ready=0, all currents Z.
  - Held regardless of supplies. Exit only via pdb=0 → OFF, which clears fault.
- pdb=0 in CHECK/RAMP/ON:
  - Next edge → OFF.
  - All outputs Z and ready=0 from that edge. No ramp-down.
- IUNIT tracks iref_500ua continuously. Currents already enabled follow iref changes without a clock.
- ATB, combinational, driven only when pdb=1 and state≠OFF, else both Z:
  - 00: both Z.
  - 01: atb1=vddana_1p8, atb0=vssana.
  - 10: atb1=vddana_0p8, atb0=Iout_therm[atb_sel]; atb_sel≥N_THERM gives atb0=Z.
  - 11: atb1=iref_500ua, atb0=Iout_binary_red.
- On each check-failure edge, issue one $warning naming the failing input. No warning on repeated cycles of the same failure.
- Timing: ready rises DEB_CYCLES + (N_THERM+1)*RAMP_STEP edges after the first edge sampling pdb=1 with good. Defaults give 80.

Decomposition:
- Package csu_pkg holds:
  - nominal constants IREF_NOM=500e-6, VDD1P8_NOM, VDD0P8_NOM, VSS_WIN;
  - state enum csu_state_e;
  - helper function in_window(real v, real nom, real tol).
- Sub-module csu_supply_monitor holds the four window checks, the good output and the warning generation.
- Sequencer and output drive stay in the top module.

Test Plan:
- Nominal power-up: iref=500e-6, supplies 1.8/0.8/0.0, pdb↑.
  - ready=1 at edge 80.
  - Iout_therm[16]=200e-6, Iout_binary[5]=100e-6, Iout_binary_red=3.125e-6.
  - Iout_therm[3] first non-Z at edge 8+16.
- Reset mid-RAMP: rstb=0 at edge 40.
  - All outputs Z immediately (no clock), ready=0, fault=0.
  - After release, sequence restarts from CHECK.
- Fault debounce:
  - In ON, vddana_1p8=1.6 for 7 cycles → no fault, ready stays 1.
  - Held 8 cycles → fault=1 with all currents Z.
  - Restoring 1.8 V keeps fault=1; pdb toggle 0→1 re-runs power-up.
- CHECK debounce: iref=400e-6 during CHECK (out of ±10%) holds the state in CHECK. Returning iref=500e-6 reaches RAMP 8 cycles later.
- ATB modes in ON:
  - atb_ena=10, atb_sel=5 → atb1=0.8, atb0=200e-6.
  - atb_sel=20 → atb0=Z.
  - atb_ena=11 → atb1=500e-6, atb0=3.125e-6.
  - atb_ena=00 → both Z.
- Parameter sweep N_THERM=8, N_BIN=4, RAMP_STEP=1:
  - ready at edge 8+9=17.
  - Iout_binary[0]=12.5e-6 with iref=500e-6.

Source files
------------

// File: rtl/current_source_array_pkg.sv
// ---------------------------------------------------------------------------
// csu_pkg
// Shared definitions for the current_source_array unit-current block:
//   - nominal reference/supply values used by the supply monitor
//   - the real value carried by an undriven (high-impedance) real output
//   - the sequencer state encoding
//   - in_window(): absolute-window check used for every supply/reference test
// ---------------------------------------------------------------------------
package csu_pkg;

  localparam real IREF_NOM   = 500.0e-6;
  localparam real VDD1P8_NOM = 1.8;
  localparam real VDD0P8_NOM = 0.8;
  localparam real VSS_WIN    = 0.05;

  // Stand-in for wrealZState: a real output carrying this value is undriven.
  // It sits far outside any physical current or voltage of this macro, so a
  // consumer can never confuse it with a driven level.
  localparam real CSU_REAL_Z = 1.0e30;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_CHECK = 3'd1,
    ST_RAMP  = 3'd2,
    ST_ON    = 3'd3,
    ST_FAULT = 3'd4
  } csu_state_e;

  // True when v lies within nom +/- tol. tol is an absolute half-width, so
  // relative windows are formed by the caller as nom*rel.
  function automatic logic in_window(input real v, input real nom, input real tol);
    return ((v - nom) <= tol) && ((nom - v) <= tol);
  endfunction

endpackage

// File: rtl/current_source_array_if.sv
// ---------------------------------------------------------------------------
// current_source_array_if
// Bundles the control, analog inputs and real-valued outputs of
// current_source_array.
//   master : drives pdb, atb_ena, atb_sel, iref_500ua, supplies;
//            observes currents, test bus, ready, fault
//   slave  : the array itself (mirror of master)
// ---------------------------------------------------------------------------
interface current_source_array_if #(
  parameter int N_THERM = 17,
  parameter int N_BIN   = 6
);
  logic                       pdb;
  logic [1:0]                 atb_ena;
  logic [$clog2(N_THERM)-1:0] atb_sel;
  real                        iref_500ua;
  real                        vddana_1p8;
  real                        vddana_0p8;
  real                        vssana;
  real                        Iout_therm [N_THERM];
  real                        Iout_binary [N_BIN];
  real                        Iout_binary_red;
  real                        atb1;
  real                        atb0;
  logic                       ready;
  logic                       fault;

  modport master (
    output pdb, atb_ena, atb_sel, iref_500ua, vddana_1p8, vddana_0p8, vssana,
    input  Iout_therm, Iout_binary, Iout_binary_red, atb1, atb0, ready, fault
  );

  modport slave (
    input  pdb, atb_ena, atb_sel, iref_500ua, vddana_1p8, vddana_0p8, vssana,
    output Iout_therm, Iout_binary, Iout_binary_red, atb1, atb0, ready, fault
  );
endinterface

// File: rtl/current_source_array_supply_monitor.sv
// ---------------------------------------------------------------------------
// csu_supply_monitor
// Window checks on the reference current and the three supplies.
//   clk, rstb : sequencer clock, asynchronous active-low reset
//   i_iref    : iref_500ua, must be within IREF_NOM*(1 +/- IREF_TOL)
//   i_vdd1p8  : within 1.8 V*(1 +/- VDD_TOL)
//   i_vdd0p8  : within 0.8 V*(1 +/- VDD_TOL)
//   i_vss     : within +/- VSS_WIN absolute
//   o_good    : all four checks pass (combinational)
// One warning is issued on the edge where a check first goes bad; it is not
// repeated while that check stays bad.
// ---------------------------------------------------------------------------
module csu_supply_monitor
  import csu_pkg::*;
#(
  parameter real IREF_TOL = 0.10,
  parameter real VDD_TOL  = 0.05
) (
  input  logic clk,
  input  logic rstb,
  input  real  i_iref,
  input  real  i_vdd1p8,
  input  real  i_vdd0p8,
  input  real  i_vss,
  output logic o_good
);

  logic [3:0] w_ok;
  logic [3:0] r_ok_prev;

  assign w_ok[0] = in_window(i_iref,   IREF_NOM,   IREF_NOM * IREF_TOL);
  assign w_ok[1] = in_window(i_vdd1p8, VDD1P8_NOM, VDD1P8_NOM * VDD_TOL);
  assign w_ok[2] = in_window(i_vdd0p8, VDD0P8_NOM, VDD0P8_NOM * VDD_TOL);
  assign w_ok[3] = in_window(i_vss,    0.0,        VSS_WIN);
  assign o_good  = &w_ok;

  // r_ok_prev starts all-good so the first bad sample after reset reports.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ok_prev <= '1;
    end else begin
      r_ok_prev <= w_ok;
      if (r_ok_prev[0] && !w_ok[0]) $warning("csu_supply_monitor: iref_500ua out of window (%g)", i_iref);
      if (r_ok_prev[1] && !w_ok[1]) $warning("csu_supply_monitor: vddana_1p8 out of window (%g)", i_vdd1p8);
      if (r_ok_prev[2] && !w_ok[2]) $warning("csu_supply_monitor: vddana_0p8 out of window (%g)", i_vdd0p8);
      if (r_ok_prev[3] && !w_ok[3]) $warning("csu_supply_monitor: vssana out of window (%g)", i_vss);
    end
  end

endmodule

// File: rtl/current_source_array.sv
// ---------------------------------------------------------------------------
// current_source_array
// Thermometer + binary unit-current array for the current-steering DAC with
// debounced supply monitoring, one-unit-at-a-time soft start and a latched
// fault state.
//   clk  : sequencer clock
//   rstb : asynchronous active-low reset (state OFF, all real outputs Z)
//   bus  : current_source_array_if.slave -- pdb, atb_ena, atb_sel,
//          iref_500ua, supplies in; Iout_therm[], Iout_binary[],
//          Iout_binary_red, atb1, atb0, ready, fault out
// Undriven real outputs carry CSU_REAL_Z. Enabled currents are derived
// combinationally from iref_500ua, so they track it without a clock.
// ---------------------------------------------------------------------------
module current_source_array
  import csu_pkg::*;
#(
  parameter int  N_THERM    = 17,
  parameter int  N_BIN      = 6,
  parameter real RATIO      = 0.4,
  parameter int  RAMP_STEP  = 4,
  parameter int  DEB_CYCLES = 8,
  parameter real IREF_TOL   = 0.10,
  parameter real VDD_TOL    = 0.05
) (
  input logic                   clk,
  input logic                   rstb,
  current_source_array_if.slave bus
);

  localparam logic [2:0] S_OFF   = 3'(ST_OFF);
  localparam logic [2:0] S_CHECK = 3'(ST_CHECK);
  localparam logic [2:0] S_RAMP  = 3'(ST_RAMP);
  localparam logic [2:0] S_ON    = 3'(ST_ON);
  localparam logic [2:0] S_FAULT = 3'(ST_FAULT);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(RAMP_STEP + 1);
  localparam int NW = $clog2(N_THERM + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(RAMP_STEP - 1);
  localparam logic [NW-1:0] N_FULL    = NW'(N_THERM);

  logic [2:0]    r_state,    w_state_next;
  logic [DW-1:0] r_deb_cnt,  w_deb_next;
  logic [DW-1:0] r_bad_cnt,  w_bad_next;
  logic [SW-1:0] r_step_cnt, w_step_next;
  logic [NW-1:0] r_n_on,     w_n_on_next;
  logic          w_good;
  logic          w_on;
  logic          w_ramp;
  real           w_iunit;
  int            w_sel;
  real           w_atb1;
  real           w_atb0;

  csu_supply_monitor #(
    .IREF_TOL (IREF_TOL),
    .VDD_TOL  (VDD_TOL)
  ) u_monitor (
    .clk      (clk),
    .rstb     (rstb),
    .i_iref   (bus.iref_500ua),
    .i_vdd1p8 (bus.vddana_1p8),
    .i_vdd0p8 (bus.vddana_0p8),
    .i_vss    (bus.vssana),
    .o_good   (w_good)
  );

  always_comb begin
    w_state_next = r_state;
    w_deb_next   = r_deb_cnt;
    w_bad_next   = r_bad_cnt;
    w_step_next  = r_step_cnt;
    w_n_on_next  = r_n_on;
    case (r_state)
      S_OFF: begin
        if (bus.pdb) begin
          w_state_next = S_CHECK;
          w_deb_next   = '0;
        end
      end
      S_CHECK: begin
        if (!bus.pdb) begin
          w_state_next = S_OFF;
        end else if (!w_good) begin
          w_deb_next = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          // This good sample is the DEB_CYCLES-th in a row.
          w_state_next = S_RAMP;
          w_deb_next   = '0;
          w_bad_next   = '0;
          w_step_next  = '0;
          w_n_on_next  = '0;
        end else begin
          w_deb_next = r_deb_cnt + 1'b1;
        end
      end
      S_RAMP, S_ON: begin
        if (!bus.pdb) begin
          w_state_next = S_OFF;
        end else if (!w_good && (r_bad_cnt == DEB_LAST)) begin
          w_state_next = S_FAULT;
        end else begin
          w_bad_next = w_good ? '0 : r_bad_cnt + 1'b1;
          if (r_state == S_RAMP) begin
            if (r_step_cnt == STEP_LAST) begin
              w_step_next = '0;
              // One extra step period after the last unit before going ON.
              if (r_n_on == N_FULL) w_state_next = S_ON;
              else                  w_n_on_next  = r_n_on + 1'b1;
            end else begin
              w_step_next = r_step_cnt + 1'b1;
            end
          end
        end
      end
      S_FAULT: begin
        if (!bus.pdb) w_state_next = S_OFF;
      end
      default: w_state_next = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= S_OFF;
      r_deb_cnt  <= '0;
      r_bad_cnt  <= '0;
      r_step_cnt <= '0;
      r_n_on     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_deb_cnt  <= w_deb_next;
      r_bad_cnt  <= w_bad_next;
      r_step_cnt <= w_step_next;
      r_n_on     <= w_n_on_next;
    end
  end

  assign w_on      = (r_state == S_ON);
  assign w_ramp    = (r_state == S_RAMP);
  assign w_iunit   = bus.iref_500ua * RATIO;
  assign bus.ready = w_on;
  assign bus.fault = (r_state == S_FAULT);

  genvar gi;
  generate
    for (gi = 0; gi < N_THERM; gi++) begin : g_therm
      assign bus.Iout_therm[gi] = (w_on || (w_ramp && (NW'(gi) < r_n_on))) ? w_iunit : CSU_REAL_Z;
    end
    for (gi = 0; gi < N_BIN; gi++) begin : g_bin
      assign bus.Iout_binary[gi] = w_on ? (w_iunit / real'(1 << (N_BIN - gi))) : CSU_REAL_Z;
    end
  endgenerate

  assign bus.Iout_binary_red = w_on ? (w_iunit / real'(1 << N_BIN)) : CSU_REAL_Z;

  // Test bus: purely combinational, released as soon as pdb drops.
  assign w_sel = int'(bus.atb_sel);

  always_comb begin
    w_atb1 = CSU_REAL_Z;
    w_atb0 = CSU_REAL_Z;
    if (bus.pdb && (r_state != S_OFF)) begin
      case (bus.atb_ena)
        2'b01: begin
          w_atb1 = bus.vddana_1p8;
          w_atb0 = bus.vssana;
        end
        2'b10: begin
          w_atb1 = bus.vddana_0p8;
          if (w_sel < N_THERM) w_atb0 = bus.Iout_therm[bus.atb_sel];
        end
        2'b11: begin
          w_atb1 = bus.iref_500ua;
          w_atb0 = bus.Iout_binary_red;
        end
        default: ;
      endcase
    end
  end

  assign bus.atb1 = w_atb1;
  assign bus.atb0 = w_atb0;

endmodule

// File: tb/tb_current_source_array.sv
module tb_current_source_array;
  import csu_pkg::*;

  localparam real ZR = CSU_REAL_Z;

  logic clk = 1'b0;
  logic rstb;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  current_source_array_if #(.N_THERM(17), .N_BIN(6)) bus ();
  current_source_array_if #(.N_THERM(8),  .N_BIN(4)) bus2 ();

  current_source_array dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  current_source_array #(.N_THERM(8), .N_BIN(4), .RAMP_STEP(1)) dut2 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus2)
  );

  typedef struct {
    logic [1:0] ena;
    logic [4:0] sel;
    real        exp1;
    real        exp0;
  } atb_vec_t;

  atb_vec_t vecs [7];

  function automatic bit near(input real a, input real b);
    real d;
    real m;
    if ((a == ZR) || (b == ZR)) return (a == b);
    d = (a > b) ? (a - b) : (b - a);
    m = (b < 0.0) ? -b : b;
    return d <= (m * 1.0e-9 + 1.0e-15);
  endfunction

  task automatic chk_r(input string name, input real act, input real exp);
    n_chk++;
    if (!near(act, exp)) begin
      n_err++;
      $display("FAIL %s: got %g, expected %g", name, act, exp);
    end else begin
      $display("ok   %s: %g", name, act);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // Advance n rising edges, then settle 2 time units past the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #2;
  endtask

  initial begin
    // mode, sel, expected atb1, expected atb0 (IUNIT = 200e-6 in ON)
    vecs[0] = '{2'b10, 5'd5,  0.8,    200.0e-6};
    vecs[1] = '{2'b10, 5'd20, 0.8,    ZR};
    vecs[2] = '{2'b11, 5'd0,  500e-6, 3.125e-6};
    vecs[3] = '{2'b00, 5'd0,  ZR,     ZR};
    vecs[4] = '{2'b01, 5'd0,  1.8,    0.0};
    vecs[5] = '{2'b10, 5'd16, 0.8,    200.0e-6};
    vecs[6] = '{2'b10, 5'd17, 0.8,    ZR};

    rstb            = 1'b1;
    bus.pdb         = 1'b0;
    bus.atb_ena     = 2'b00;
    bus.atb_sel     = '0;
    bus.iref_500ua  = 500e-6;
    bus.vddana_1p8  = 1.8;
    bus.vddana_0p8  = 0.8;
    bus.vssana      = 0.0;
    bus2.pdb        = 1'b0;
    bus2.atb_ena    = 2'b00;
    bus2.atb_sel    = '0;
    bus2.iref_500ua = 500e-6;
    bus2.vddana_1p8 = 1.8;
    bus2.vddana_0p8 = 0.8;
    bus2.vssana     = 0.0;
    #1 rstb = 1'b0;
    #22;

    // Reset state
    chk_b("reset ready", bus.ready, 1'b0);
    chk_b("reset fault", bus.fault, 1'b0);
    chk_r("reset therm0", bus.Iout_therm[0], ZR);
    chk_r("reset bin5", bus.Iout_binary[5], ZR);
    chk_r("reset red", bus.Iout_binary_red, ZR);
    chk_r("reset atb1", bus.atb1, ZR);
    @(negedge clk);
    rstb = 1'b1;
    step(3);
    chk_r("off therm16", bus.Iout_therm[16], ZR);

    // Nominal power-up, with the small parameter set alongside
    bus.pdb  = 1'b1;
    bus2.pdb = 1'b1;
    step(1);  // edge 0
    for (int e = 1; e <= 80; e++) begin
      step(1);
      if (e == 16) chk_b("sweep ready edge16", bus2.ready, 1'b0);
      if (e == 17) begin
        chk_b("sweep ready edge17", bus2.ready, 1'b1);
        chk_r("sweep bin0", bus2.Iout_binary[0], 12.5e-6);
      end
      if (e == 23) chk_r("therm3 edge23", bus.Iout_therm[3], ZR);
      if (e == 24) begin
        chk_r("therm3 edge24", bus.Iout_therm[3], 200e-6);
        chk_r("therm4 edge24", bus.Iout_therm[4], ZR);
      end
      if (e == 79) chk_b("ready edge79", bus.ready, 1'b0);
      if (e == 80) chk_b("ready edge80", bus.ready, 1'b1);
    end
    chk_r("on therm16", bus.Iout_therm[16], 200e-6);
    chk_r("on bin5", bus.Iout_binary[5], 100e-6);
    chk_r("on bin0", bus.Iout_binary[0], 3.125e-6);
    chk_r("on red", bus.Iout_binary_red, 3.125e-6);
    chk_b("on fault", bus.fault, 1'b0);

    // Test bus table
    for (int i = 0; i < 7; i++) begin
      bus.atb_ena = vecs[i].ena;
      bus.atb_sel = vecs[i].sel;
      #1;
      chk_r($sformatf("atb vec%0d atb1", i), bus.atb1, vecs[i].exp1);
      chk_r($sformatf("atb vec%0d atb0", i), bus.atb0, vecs[i].exp0);
    end
    bus.atb_ena = 2'b00;

    // Enabled currents follow iref without a clock
    bus.iref_500ua = 480e-6;
    #1;
    chk_r("track therm0", bus.Iout_therm[0], 192e-6);
    chk_r("track bin5", bus.Iout_binary[5], 96e-6);
    bus.iref_500ua = 500e-6;
    #1;

    // Fault debounce: 7 bad cycles ignored, 8 latch fault
    bus.vddana_1p8 = 1.6;
    step(7);
    chk_b("glitch7 fault", bus.fault, 1'b0);
    chk_b("glitch7 ready", bus.ready, 1'b1);
    bus.vddana_1p8 = 1.8;
    step(1);
    bus.vddana_1p8 = 1.6;
    step(7);
    chk_b("bad7 fault", bus.fault, 1'b0);
    step(1);
    chk_b("bad8 fault", bus.fault, 1'b1);
    chk_b("bad8 ready", bus.ready, 1'b0);
    chk_r("fault therm0", bus.Iout_therm[0], ZR);
    chk_r("fault bin5", bus.Iout_binary[5], ZR);
    chk_r("fault red", bus.Iout_binary_red, ZR);
    bus.vddana_1p8 = 1.8;
    step(5);
    chk_b("fault held", bus.fault, 1'b1);
    bus.pdb = 1'b0;
    step(1);
    chk_b("pdb0 clears fault", bus.fault, 1'b0);
    bus.pdb = 1'b1;
    step(1);  // edge 0
    step(79);
    chk_b("rerun ready edge79", bus.ready, 1'b0);
    step(1);
    chk_b("rerun ready edge80", bus.ready, 1'b1);

    // Reset in the middle of the ramp
    bus.atb_ena = 2'b01;
    bus.pdb = 1'b0;
    step(1);
    bus.pdb = 1'b1;
    step(1);  // edge 0
    step(40);
    chk_r("ramp40 therm7", bus.Iout_therm[7], 200e-6);
    chk_r("ramp40 therm8", bus.Iout_therm[8], ZR);
    chk_r("ramp40 atb1", bus.atb1, 1.8);
    rstb = 1'b0;
    #1;
    chk_r("async rst therm0", bus.Iout_therm[0], ZR);
    chk_r("async rst atb1", bus.atb1, ZR);
    chk_b("async rst ready", bus.ready, 1'b0);
    chk_b("async rst fault", bus.fault, 1'b0);
    @(negedge clk);
    rstb = 1'b1;
    step(1);  // edge 0
    for (int e = 1; e <= 80; e++) begin
      step(1);
      if (e == 11) chk_r("restart therm0 edge11", bus.Iout_therm[0], ZR);
      if (e == 12) chk_r("restart therm0 edge12", bus.Iout_therm[0], 200e-6);
      if (e == 79) chk_b("restart ready edge79", bus.ready, 1'b0);
      if (e == 80) chk_b("restart ready edge80", bus.ready, 1'b1);
    end

    // CHECK held by a bad reference, released 8 good cycles later
    bus.pdb = 1'b0;
    step(1);
    bus.iref_500ua = 400e-6;
    bus.pdb = 1'b1;
    step(1);  // edge 0
    step(20);
    chk_r("check hold therm0", bus.Iout_therm[0], ZR);
    bus.iref_500ua = 500e-6;
    step(11);
    chk_r("check rel therm0 edge31", bus.Iout_therm[0], ZR);
    step(1);
    chk_r("check rel therm0 edge32", bus.Iout_therm[0], 200e-6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
